pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sits directly downstream of the 125/25 MHz ECP5 PLL and consumes its asynchronous `locked` output. It runs on the stable 25 MHz board reference clock, the same clock that feeds the PLL input. It drives the PLL RST pin and only releases the design reset once lock has been held continuously for a qualification window. It re-arms on lock loss and re-pulses PLL RST if lock is not achieved within a timeout.

Parameters:
SYNC_STAGES, 2, number of flops in the `pll_locked` synchroniser (minimum 2).
RST_CYCLES, 16, number of cycles `pll_rst` is held high per reset attempt.
STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before `sys_reset` is released.
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a new PLL reset attempt (2.6 ms at 25 MHz).
CNT_W, 8, width of the status counters.

Ports:
clock  input  1  25 MHz board reference clock (same net as PLL clkin).
reset_n  input  1  asynchronous active-low reset; deassertion is synchronised by the caller.
pll_locked  input  1  PLL LOCK output, asynchronous to `clock`.
pll_rst  output  1  PLL RST request, active-high.
sys_reset  output  1  active-high reset for logic clocked by the PLL outputs.
ready  output  1  high exactly while in RUN.
lock_loss_count  output  CNT_W  number of RUN→WAIT_LOCK transitions (feature-dependent).
retry_count  output  CNT_W  number of timeout-triggered PLL resets (feature-dependent).

Behaviour:
- Single clock domain. One shared down/up timer sized to clog2(max(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT))+1 bits.
- `pll_locked` passes through SYNC_STAGES flops to form `lk`. All decisions use `lk` only.
- Reset (reset_n low, asynchronous) puts outputs in the following state:
  - state=PLL_RESET, timer=0
  - pll_rst=1, sys_reset=1, ready=0, counters=0
  - synchroniser flops=0
- All outputs are registered.
- FSM:
  - PLL_RESET: pll_rst=1 and timer counts. After RST_CYCLES cycles in this state, pll_rst is 0 from the next cycle; go to WAIT_LOCK with timer=0.
  - WAIT_LOCK: timer counts.
    - If lk=1, go to STABLE with timer=0.
    - Else, if timer reaches LOCK_TIMEOUT-1, go to PLL_RESET and increment retry_count.
    - Simultaneous lk=1 and timeout: lk wins.
  - STABLE: lk=1 increments timer. lk=0 returns to WAIT_LOCK with timer=0; this is not counted as a loss. When timer reaches STABLE_CYCLES-1 with lk=1, go to RUN.
  - RUN: sys_reset=0 and ready=1 from the first cycle in RUN. If lk=0, go to WAIT_LOCK and increment lock_loss_count; sys_reset=1 and ready=0 on the next clock edge.
- sys_reset is 1 in every state except RUN. Latency from `pll_locked` rising edge to sys_reset low is SYNC_STAGES+STABLE_CYCLES+1 cycles (nominal).
- Counters saturate at 2^CNT_W-1 and never wrap.
- A lock glitch shorter than one clock may be missed by the synchroniser. This is accepted.
- reset_n asserted mid-operation: the block returns immediately (asynchronously) to the reset values above.

Optional Feature:
Macro: PLL_RESET_SEQUENCER_STATUS_EN.
- Defined: lock_loss_count and retry_count registers are implemented as described.
- Undefined: both ports are tied to 0, no counter flops exist, and the FSM is otherwise identical.

Decomposition:
- Shared package pll_seq_pkg holds:
  - state enum {PLL_RESET, WAIT_LOCK, STABLE, RUN}
  - timer width function/constant
  - saturating-increment function
- One natural sub-module: sync_bit (parameterised N-flop synchroniser with async active-low reset). It is reusable for other asynchronous status inputs.

Test Plan:
1. Defaults, pll_locked held 0 → pll_rst high for exactly 16 cycles after reset_n release, then low for 65536 cycles. Then pll_rst re-pulses for 16 cycles and retry_count=1.
2. STABLE_CYCLES=8, pll_locked rises 5 cycles after pll_rst falls → sys_reset falls exactly 2+8+1 cycles after the rise. ready=1 on the same cycle; lock_loss_count=0.
3. In RUN, drop pll_locked for 3 cycles → sys_reset=1 within SYNC_STAGES+1 cycles and lock_loss_count=1. sys_reset is released again after a further full STABLE window.
4. In STABLE (timer=5 of 8), pulse pll_locked low for 2 cycles → return to WAIT_LOCK with timer restarted, sys_reset never deasserted, and lock_loss_count unchanged.
5. CNT_W=2, force 5 timeouts → retry_count reads 3 after the 3rd, 4th and 5th timeouts. Build without PLL_RESET_SEQUENCER_STATUS_EN → both counters read 0 throughout.
6. Assert reset_n mid-RUN, off-clock-edge → sys_reset=1, pll_rst=1 and ready=0 immediately (asynchronously). The sequence restarts from PLL_RESET on release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   seq_state_t  - sequencer FSM states
//   timer_width  - width of the shared sequencing timer for a set of limits
//   sat_inc      - saturating increment used by the status counters
`timescale 1ns/1ps

package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // One timer serves every state, so it is sized for the largest limit
  // plus one spare bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// sync_bit
// N-flop synchroniser for a single asynchronous level input. Reusable for
// any slow asynchronous status signal.
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low reset, clears every stage to 0
//   d       - asynchronous input
//   q       - synchronised output, N clocks of latency
`timescale 1ns/1ps

module sync_bit #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // Fewer than two flops gives no metastability protection, so clamp.
  localparam int NS = (N < 2) ? 2 : N;

  logic [NS-1:0] stages;

  // Shift register: stage 0 samples the asynchronous input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[NS-2:0], d};
    end
  end

  assign q = stages[NS-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Drives the ECP5 PLL RST pin and holds the PLL-domain system reset until
// the PLL has reported lock continuously for a qualification window. Lock
// loss re-arms the sequence; failure to lock within a timeout re-pulses
// the PLL reset.
// Ports:
//   clock           - 25 MHz board reference clock (same net as PLL clkin)
//   reset_n         - asynchronous active-low reset
//   pll_locked      - PLL LOCK output, asynchronous to clock
//   pll_rst         - PLL RST request, active-high
//   sys_reset       - active-high reset for logic on the PLL outputs
//   ready           - high exactly while the sequencer is in RUN
//   lock_loss_count - saturating count of RUN -> WAIT_LOCK transitions
//   retry_count     - saturating count of timeout-triggered PLL resets
// Build option:
//   PLL_RESET_SEQUENCER_STATUS_EN - when defined the two status counters
//   are implemented; otherwise both ports are tied to 0.
`timescale 1ns/1ps

module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] retry_count
);

  import pll_seq_pkg::*;

  localparam int TW = timer_width(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);

  // Terminal timer values: each state exits on the cycle its timer
  // reaches limit-1, which makes the state last exactly 'limit' cycles.
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);

  seq_state_t    state;
  logic [TW-1:0] timer;
  logic          lk;

  sync_bit #(
    .N(SYNC_STAGES)
  ) u_lock_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (pll_locked),
    .q      (lk)
  );

  // Sequencer FSM. Outputs are registered and updated on the same edge as
  // the state change, so they always reflect the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PLL_RESET;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (timer == RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        // Lock is checked before the timeout so a lock that arrives on
        // the final cycle is still accepted.
        WAIT_LOCK: begin
          if (lk) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            state   <= PLL_RESET;
            timer   <= '0;
            pll_rst <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        // Any dropout during qualification restarts the wait; it is not
        // reported as a lock loss because the design was never released.
        STABLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state     <= RUN;
            timer     <= '0;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            state     <= WAIT_LOCK;
            timer     <= '0;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
          end
        end
        default: begin
          state     <= PLL_RESET;
          timer     <= '0;
          pll_rst   <= 1'b1;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RESET_SEQUENCER_STATUS_EN
  logic loss_event;
  logic retry_event;

  // Events mirror the FSM transitions that leave RUN on lock loss and
  // leave WAIT_LOCK on timeout.
  assign loss_event  = (state == RUN) && !lk;
  assign retry_event = (state == WAIT_LOCK) && !lk && (timer == TO_LAST);

  // Status counters saturate rather than wrap so a large count stays
  // meaningful.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
      retry_count     <= '0;
    end else begin
      if (loss_event) begin
        lock_loss_count <= CNT_W'(sat_inc(32'(lock_loss_count), CNT_W));
      end
      if (retry_event) begin
        retry_count <= CNT_W'(sat_inc(32'(retry_count), CNT_W));
      end
    end
  end
`else
  assign lock_loss_count = '0;
  assign retry_count     = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Two sequencer instances share one 25 MHz clock and reset:
//   dut_a - default parameters, used for the full-length timeout check
//   dut_b - short windows (STABLE 8, timeout 64, CNT_W 2) driven by a
//           table of {pll_locked, cycles, expected outputs} records
`timescale 1ns/1ps

module tb_pll_reset_sequencer;

  localparam int B_CNT_W = 2;

`ifdef PLL_RESET_SEQUENCER_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic a_locked, b_locked;

  logic         a_pll_rst, a_sys_reset, a_ready;
  logic [7:0]   a_loss, a_retry;
  logic         b_pll_rst, b_sys_reset, b_ready;
  logic [B_CNT_W-1:0] b_loss, b_retry;

  int errors = 0;
  int checks = 0;

  always #20 clock = ~clock;

  pll_reset_sequencer dut_a (
    .clock          (clock),
    .reset_n        (reset_n),
    .pll_locked     (a_locked),
    .pll_rst        (a_pll_rst),
    .sys_reset      (a_sys_reset),
    .ready          (a_ready),
    .lock_loss_count(a_loss),
    .retry_count    (a_retry)
  );

  pll_reset_sequencer #(
    .SYNC_STAGES  (2),
    .RST_CYCLES   (16),
    .STABLE_CYCLES(8),
    .LOCK_TIMEOUT (64),
    .CNT_W        (B_CNT_W)
  ) dut_b (
    .clock          (clock),
    .reset_n        (reset_n),
    .pll_locked     (b_locked),
    .pll_rst        (b_pll_rst),
    .sys_reset      (b_sys_reset),
    .ready          (b_ready),
    .lock_loss_count(b_loss),
    .retry_count    (b_retry)
  );

  typedef struct {
    logic locked;
    int   cycles;
    bit   every;
    logic pll_rst;
    logic sys_reset;
    logic ready;
    int   loss;
    int   retry;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic l, int c, bit e, logic r, logic s, logic y, int lo, int rt);
    vec_t v;
    v.locked = l; v.cycles = c; v.every = e;
    v.pll_rst = r; v.sys_reset = s; v.ready = y;
    v.loss = lo; v.retry = rt;
    return v;
  endfunction

  function automatic int expCnt(int v);
    return STATUS_EN ? v : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkB(input string tag, input vec_t v);
    checkOutput({tag, " pll_rst"},   int'(b_pll_rst),   int'(v.pll_rst));
    checkOutput({tag, " sys_reset"}, int'(b_sys_reset), int'(v.sys_reset));
    checkOutput({tag, " ready"},     int'(b_ready),     int'(v.ready));
    checkOutput({tag, " loss"},      int'(b_loss),      expCnt(v.loss));
    checkOutput({tag, " retry"},     int'(b_retry),     expCnt(v.retry));
  endtask

  // Drives one table record starting at a falling edge and samples on the
  // falling edge after each rising edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    b_locked = v.locked;
    for (int c = 0; c < v.cycles; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (v.every || c == v.cycles - 1) checkB($sformatf("vec%0d.%0d", idx, c), v);
    end
  endtask

  // Counts rising edges until a_pll_rst / b_pll_rst reaches target;
  // returns -1 if the bound expires.
  task automatic edgesUntilRst(input bit use_a, input logic target, input int bound, output int n);
    n = -1;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clock);
      @(negedge clock);
      if ((use_a ? a_pll_rst : b_pll_rst) === target) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;

    // Reference sequence for dut_b, times in clock edges after reset release.
    vecs.push_back(mk(0, 15, 1, 1, 1, 0, 0, 0));  // PLL RST held
    vecs.push_back(mk(0,  1, 0, 0, 1, 0, 0, 0));  // released on 16th edge
    vecs.push_back(mk(0,  5, 1, 0, 1, 0, 0, 0));  // WAIT_LOCK, lock 5 cycles later
    vecs.push_back(mk(1, 10, 1, 0, 1, 0, 0, 0));  // sync + qualification
    vecs.push_back(mk(1,  1, 0, 0, 0, 1, 0, 0));  // released 2+8+1 after rise
    vecs.push_back(mk(0,  2, 1, 0, 0, 1, 0, 0));  // dropout still in synchroniser
    vecs.push_back(mk(0,  1, 0, 0, 1, 0, 1, 0));  // lock loss seen, counted
    vecs.push_back(mk(1, 10, 1, 0, 1, 0, 1, 0));  // relock, full window again
    vecs.push_back(mk(1,  1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0,  3, 0, 0, 1, 0, 2, 0));  // second loss
    vecs.push_back(mk(0,  5, 1, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1,  8, 1, 0, 1, 0, 2, 0));  // STABLE timer reaches 5
    vecs.push_back(mk(0,  2, 1, 0, 1, 0, 2, 0));  // 2-cycle glitch in STABLE
    vecs.push_back(mk(1, 10, 1, 0, 1, 0, 2, 0));  // window restarted, no loss
    vecs.push_back(mk(1,  1, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0,  3, 0, 0, 1, 0, 3, 0));  // third loss -> saturated
    vecs.push_back(mk(0, 63, 0, 0, 1, 0, 3, 0));  // timeout window
    vecs.push_back(mk(0,  1, 0, 1, 1, 0, 3, 1));  // 1st timeout
    vecs.push_back(mk(0, 15, 1, 1, 1, 0, 3, 1));
    vecs.push_back(mk(0,  1, 0, 0, 1, 0, 3, 1));
    vecs.push_back(mk(0, 63, 0, 0, 1, 0, 3, 1));
    vecs.push_back(mk(0,  1, 0, 1, 1, 0, 3, 2));  // 2nd timeout
    vecs.push_back(mk(0, 79, 0, 0, 1, 0, 3, 2));
    vecs.push_back(mk(0,  1, 0, 1, 1, 0, 3, 3));  // 3rd timeout
    vecs.push_back(mk(0, 79, 0, 0, 1, 0, 3, 3));
    vecs.push_back(mk(0,  1, 0, 1, 1, 0, 3, 3));  // 4th, saturated
    vecs.push_back(mk(0, 79, 0, 0, 1, 0, 3, 3));
    vecs.push_back(mk(0,  1, 0, 1, 1, 0, 3, 3));  // 5th, saturated
    vecs.push_back(mk(0, 16, 0, 0, 1, 0, 3, 3));
    vecs.push_back(mk(0, 61, 0, 0, 1, 0, 3, 3));
    vecs.push_back(mk(1,  3, 1, 0, 1, 0, 3, 3));  // lock on the timeout cycle wins
    vecs.push_back(mk(1,  7, 1, 0, 1, 0, 3, 3));
    vecs.push_back(mk(1,  1, 0, 0, 0, 1, 3, 3));

    reset_n  = 1'b0;
    a_locked = 1'b0;
    b_locked = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("rst b pll_rst",   int'(b_pll_rst),   1);
    checkOutput("rst b sys_reset", int'(b_sys_reset), 1);
    checkOutput("rst b ready",     int'(b_ready),     0);
    checkOutput("rst b loss",      int'(b_loss),      0);
    checkOutput("rst b retry",     int'(b_retry),     0);

    reset_n = 1'b1;
    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Asynchronous reset in the middle of a clock low phase while in RUN.
    #7;
    reset_n = 1'b0;
    #1;
    checkOutput("async pll_rst",   int'(b_pll_rst),   1);
    checkOutput("async sys_reset", int'(b_sys_reset), 1);
    checkOutput("async ready",     int'(b_ready),     0);
    checkOutput("async loss",      int'(b_loss),      0);
    checkOutput("async retry",     int'(b_retry),     0);
    @(negedge clock);
    reset_n = 1'b1;
    edgesUntilRst(1'b0, 1'b0, 100, n);
    checkOutput("restart b pll_rst width", n, 16);
    checkOutput("restart b sys_reset", int'(b_sys_reset), 1);

    // Full-length timeout with default parameters and lock never present.
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("rst a pll_rst", int'(a_pll_rst), 1);
    checkOutput("rst a retry",   int'(a_retry),   0);
    reset_n = 1'b1;
    edgesUntilRst(1'b1, 1'b0, 100, n);
    checkOutput("a pll_rst width", n, 16);
    edgesUntilRst(1'b1, 1'b1, 70000, n);
    checkOutput("a wait_lock length", n, 65536);
    checkOutput("a retry", int'(a_retry), expCnt(1));
    edgesUntilRst(1'b1, 1'b0, 100, n);
    checkOutput("a pll_rst width 2", n, 16);
    checkOutput("a sys_reset", int'(a_sys_reset), 1);
    checkOutput("a ready",     int'(a_ready),     0);
    checkOutput("a loss",      int'(a_loss),      0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
